// File: rtl/q1_pkg.sv
// Shared types for the overlapping "1001" serial sequence detector.
package q1_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1001;

endpackage

// File: rtl/q1_next_state.sv
// Pure combinational next-state function of the "1001" detector.
import q1_pkg::*;

module q1_next_state #(
  parameter int MEALY = 0
) (
  input  state_t state_i,
  input  logic   j_i,
  output state_t state_o
);

  always_comb begin
    state_o = S0;
    unique case (state_i)
      S0: state_o = j_i ? S1 : S0;
      S1: state_o = j_i ? S1 : S2;
      S2: state_o = j_i ? S1 : S3;
      // Mealy flags the match combinationally, so it skips S4
      S3: state_o = j_i ? ((MEALY != 0) ? S1 : S4) : S0;
      S4: state_o = j_i ? S1 : S2;
      default: state_o = S0;
    endcase
  end

endmodule

// File: rtl/q1_fsm.sv
// Overlapping "1001" detector: state register plus Moore or Mealy
// output decode selected by MEALY.
import q1_pkg::*;

module q1_fsm #(
  parameter int MEALY = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic j,
  output logic w
);

  state_t state_q;
  state_t state_d;

  q1_next_state #(
    .MEALY (MEALY)
  ) u_next (
    .state_i (state_q),
    .j_i     (j),
    .state_o (state_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  generate
    if (MEALY != 0) begin : g_mealy
      assign w = (state_q == S3) && j;
    end else begin : g_moore
      assign w = (state_q == S4);
    end
  endgenerate

endmodule

// File: tb/tb_q1_fsm.sv
// Scoreboard bench for q1_fsm, checking Moore and Mealy instances
// side by side against a shift-history reference model.
module tb_q1_fsm;
  import q1_pkg::*;

  logic clock  = 1'b0;
  logic clk_en = 1'b1;
  logic reset  = 1'b1;
  logic j      = 1'b0;
  logic w_moore;
  logic w_mealy;

  int n_tests = 0;
  int n_fail  = 0;

  bit [3:0] hist;
  bit moore_q[$];
  bit mealy_q[$];
  logic [15:0] hit_moore;
  logic [15:0] hit_mealy;

  q1_fsm #(.MEALY(0)) u_moore (
    .clock (clock),
    .reset (reset),
    .j     (j),
    .w     (w_moore)
  );

  q1_fsm #(.MEALY(1)) u_mealy (
    .clock (clock),
    .reset (reset),
    .j     (j),
    .w     (w_mealy)
  );

  always #50 if (clk_en) clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic drive_bit(input bit b, input int idx);
    bit e;
    @(negedge clock);
    j = b;
    mealy_q.push_back((hist[2:0] == 3'b100) && b);
    #1;
    e = mealy_q.pop_front();
    n_tests++;
    if (w_mealy !== e) begin
      n_fail++;
      $display("FAIL mealy_w idx=%0d got=%b exp=%b", idx, w_mealy, e);
    end
    if (w_mealy === 1'b1) hit_mealy[idx] = 1'b1;
    @(posedge clock);
    hist = {hist[2:0], b};
    moore_q.push_back(hist == 4'b1001);
    #1;
    e = moore_q.pop_front();
    n_tests++;
    if (w_moore !== e) begin
      n_fail++;
      $display("FAIL moore_w idx=%0d got=%b exp=%b", idx, w_moore, e);
    end
    if (w_moore === 1'b1) hit_moore[idx] = 1'b1;
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) drive_bit(bits[n-1-i], i);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    j = 1'bx;
    hist = '0;
    #10;
    n_tests++;
    if (w_moore !== 1'b0 || w_mealy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulse got=%b%b exp=00", w_moore, w_mealy);
    end
    #10;
    reset = 1'b0;
    j = 1'b0;
  endtask

  task automatic check_hits(input string name, input logic [15:0] exp);
    n_tests++;
    if (hit_moore !== exp) begin
      n_fail++;
      $display("FAIL %s_moore hits got=%h exp=%h", name, hit_moore, exp);
    end
    n_tests++;
    if (hit_mealy !== exp) begin
      n_fail++;
      $display("FAIL %s_mealy hits got=%h exp=%h", name, hit_mealy, exp);
    end
    hit_moore = '0;
    hit_mealy = '0;
  endtask

  task automatic test_reset();
    // Moore in S4, then async reset with the clock stopped high
    feed(16'b1001, 4);
    n_tests++;
    if (w_moore !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_moore got=%b exp=1", w_moore);
    end
    clk_en = 1'b0;
    #20;
    reset = 1'b1;
    #1;
    n_tests++;
    if (w_moore !== 1'b0 || u_moore.state_q !== S0) begin
      n_fail++;
      $display("FAIL rst_async_moore got w=%b st=%0d exp w=0 st=0",
               w_moore, u_moore.state_q);
    end
    #10;
    reset = 1'b0;
    hist = '0;
    clk_en = 1'b1;
    // Mealy in S3 with j=1, then async reset with the clock stopped low
    feed(16'b100, 3);
    @(negedge clock);
    j = 1'b1;
    #1;
    n_tests++;
    if (w_mealy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_mealy got=%b exp=1", w_mealy);
    end
    clk_en = 1'b0;
    #5;
    reset = 1'b1;
    #1;
    n_tests++;
    if (w_mealy !== 1'b0 || u_mealy.state_q !== S0) begin
      n_fail++;
      $display("FAIL rst_async_mealy got w=%b st=%0d exp w=0 st=0",
               w_mealy, u_mealy.state_q);
    end
    #10;
    reset = 1'b0;
    j = 1'b0;
    hist = '0;
    clk_en = 1'b1;
    hit_moore = '0;
    hit_mealy = '0;
  endtask

  task automatic test_single();
    feed(16'b1001, 4);
    check_hits("single", 16'h0008);
  endtask

  task automatic test_overlap();
    feed(16'b1001001, 7);
    check_hits("overlap", 16'h0048);
  endtask

  task automatic test_long_zero();
    do_reset();
    feed(16'b1001001000100, 13);
    check_hits("long_zero", 16'h0048);
  endtask

  task automatic test_ones_run();
    do_reset();
    feed(16'b111001, 6);
    check_hits("ones_run", 16'h0020);
  endtask

  task automatic test_reset_mid();
    do_reset();
    feed(16'b100, 3);
    do_reset();
    drive_bit(1'b1, 3);
    check_hits("reset_mid", 16'h0000);
  endtask

  initial begin
    hist = '0;
    hit_moore = '0;
    hit_mealy = '0;
    #1;
    n_tests++;
    if (w_moore !== 1'b0 || w_mealy !== 1'b0) begin
      n_fail++;
      $display("FAIL init_reset got=%b%b exp=00", w_moore, w_mealy);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_single();
    test_overlap();
    test_long_zero();
    test_ones_run();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
